// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared FSM state encoding and counter-width helper for seq_mult
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Bits needed to count 0..n-1, never less than one
    function automatic int cnt_width(input int n);
        int r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/seq_mult_yadder.sv
// yAdder: parametrised ripple-carry adder, carry chain walked LSB to MSB
module yAdder #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_z
);

    logic w_c;

    // Full-adder cells chained through w_c
    always_comb begin
        w_c = i_cin;
        o_z = '0;
        for (int k = 0; k < W; k++) begin
            o_z[k] = i_a[k] ^ i_b[k] ^ w_c;
            w_c    = (i_a[k] & i_b[k]) | (w_c & (i_a[k] ^ i_b[k]));
        end
    end

endmodule

// File: rtl/seq_mult.sv
// seq_mult: radix-2 shift-add sequential multiplier, unsigned or two's-complement
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            is_signed,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] HM,
    output logic [SIZE-1:0] LM
);

    localparam int            CW   = cnt_width(SIZE);
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

    state_t            r_state, w_next;
    logic [SIZE-1:0]   r_mcand, r_mplier, r_hm, r_lm;
    logic [2*SIZE-1:0] r_acc;
    logic [CW-1:0]     r_cnt;
    logic              r_sign;

    logic [SIZE-1:0]   w_a_mag, w_b_mag;
    logic [SIZE:0]     w_addend, w_sum;
    logic [2*SIZE-1:0] w_res;

    // Magnitudes: the most negative value negates to itself, which read unsigned is 2^(SIZE-1)
    assign w_a_mag  = (is_signed && a[SIZE-1]) ? ~a + 1'b1 : a;
    assign w_b_mag  = (is_signed && b[SIZE-1]) ? ~b + 1'b1 : b;
    assign w_addend = r_mplier[0] ? {1'b0, r_mcand} : '0;
    assign w_res    = r_sign ? ~r_acc + 1'b1 : r_acc;
    assign HM       = r_hm;
    assign LM       = r_lm;

    yAdder #(.W(SIZE + 1)) u_add (
        .i_a   ({1'b0, r_acc[2*SIZE-1:SIZE]}),
        .i_b   (w_addend),
        .i_cin (1'b0),
        .o_z   (w_sum)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state and status outputs
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: w_next = start ? CALC : IDLE;
            CALC: begin
                busy   = 1'b1;
                w_next = (r_cnt == LAST) ? FIX : CALC;
            end
            FIX: begin
                busy   = 1'b1;
                w_next = DONE;
            end
            default: begin
                done   = 1'b1;
                w_next = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, shift-add steps, sign fix-up into the result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sign   <= 1'b0;
            r_hm     <= '0;
            r_lm     <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_mcand  <= w_a_mag;
                    r_mplier <= w_b_mag;
                    r_sign   <= is_signed & (a[SIZE-1] ^ b[SIZE-1]);
                    r_acc    <= '0;
                    r_cnt    <= '0;
                end
                CALC: begin
                    r_acc    <= {w_sum, r_acc[SIZE-1:1]};
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                end
                FIX: {r_hm, r_lm} <= w_res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult.sv
// tb_seq_mult: directed self-checking bench for seq_mult at SIZE=4 and SIZE=8
module tb_seq_mult;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       st4 = 1'b0, sg4 = 1'b0, bz4, dn4;
    logic [3:0] a4 = '0, b4 = '0, hm4, lm4;
    logic       st8 = 1'b0, sg8 = 1'b0, bz8, dn8;
    logic [7:0] a8 = '0, b8 = '0, hm8, lm8;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    seq_mult #(.SIZE(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(st4), .a(a4), .b(b4), .is_signed(sg4),
        .busy(bz4), .done(dn4), .HM(hm4), .LM(lm4)
    );

    seq_mult #(.SIZE(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8), .is_signed(sg8),
        .busy(bz8), .done(dn8), .HM(hm8), .LM(lm8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One multiply: checks latency, busy length, product, and that done is a single pulse
    task automatic mul(input bit w8, input logic [7:0] a, input logic [7:0] b, input bit s,
                       input logic [15:0] exp, input string tag);
        int n, nb;
        @(negedge clk);
        if (w8) begin a8 = a; b8 = b; sg8 = s; st8 = 1'b1; end
        else    begin a4 = a[3:0]; b4 = b[3:0]; sg4 = s; st4 = 1'b1; end
        @(negedge clk);
        st4 = 1'b0; st8 = 1'b0;
        a4 = ~a4; b4 = ~b4; sg4 = ~sg4; a8 = ~a8; b8 = ~b8; sg8 = ~sg8;
        n = 1; nb = 0;
        while (!(w8 ? dn8 : dn4) && n < 40) begin
            nb += int'(w8 ? bz8 : bz4);
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, n, w8 ? 10 : 6);
        chk({tag, "_busy"}, nb, w8 ? 9 : 5);
        chk({tag, "_prod"}, w8 ? {16'h0, hm8, lm8} : {24'h0, hm4, lm4}, {16'h0, exp});
        @(negedge clk);
        chk({tag, "_pulse"}, w8 ? dn8 : dn4, 0);
    endtask

    initial begin
        int n, nb;
        repeat (2) @(negedge clk);
        chk("rst4", {bz4, dn4, hm4, lm4}, 0);
        chk("rst8", {bz8, dn8, hm8, lm8}, 0);
        rst_n = 1'b1;

        mul(0, 8'd15, 8'd15, 0, 16'h00E1, "u15x15");
        mul(0, 8'h8,  8'h8,  1, 16'h0040, "sm8xm8");
        mul(0, 8'hD,  8'h5,  1, 16'h00F1, "sm3x5");
        mul(0, 8'h0,  8'h9,  1, 16'h0000, "s0xm7");
        mul(0, 8'h9,  8'h9,  0, 16'h0051, "u9x9");
        mul(0, 8'hF,  8'hF,  1, 16'h0001, "sm1xm1");
        mul(0, 8'h7,  8'h8,  1, 16'h00C8, "s7xm8");
        mul(0, 8'hF,  8'h8,  0, 16'h0078, "u15x8");

        // start held high while operands change during CALC
        @(negedge clk);
        a4 = 4'd3; b4 = 4'd5; sg4 = 1'b0; st4 = 1'b1;
        @(negedge clk);
        a4 = 4'd15; b4 = 4'd15; sg4 = 1'b1;
        n = 1;
        while (!dn4 && n < 40) begin @(negedge clk); n++; end
        st4 = 1'b0;
        chk("held_lat", n, 6);
        chk("held_prod", {hm4, lm4}, 8'h0F);
        nb = 0;
        repeat (6) begin @(negedge clk); nb += int'(bz4 | dn4); end
        chk("held_noqueue", nb, 0);
        chk("held_keep", {hm4, lm4}, 8'h0F);

        // result holds during a new CALC, then reset abandons it
        @(negedge clk);
        a4 = 4'd15; b4 = 4'd15; sg4 = 1'b0; st4 = 1'b1;
        @(negedge clk);
        st4 = 1'b0;
        @(negedge clk);
        chk("calc_busy", bz4, 1);
        chk("calc_hold", {hm4, lm4}, 8'h0F);
        rst_n = 1'b0;
        #1;
        chk("async_rst", {bz4, dn4, hm4, lm4}, 0);
        nb = 0;
        repeat (8) begin @(negedge clk); nb += int'(dn4 | bz4); end
        chk("rst_nodone", nb, 0);
        rst_n = 1'b1;
        mul(0, 8'd3, 8'd7, 0, 16'h0015, "post_rst");

        mul(1, 8'hFF, 8'hFF, 0, 16'hFE01, "u255x255");
        mul(1, 8'd200, 8'd100, 0, 16'h4E20, "u200x100");
        mul(1, 8'h80, 8'h80, 1, 16'h4000, "sm128sq");
        mul(1, 8'hFF, 8'h7F, 1, 16'hFF81, "sm1x127");
        mul(1, 8'd100, 8'hCE, 1, 16'hEC78, "s100xm50");
        mul(1, 8'h00, 8'h80, 1, 16'h0000, "s0xm128");
        mul(1, 8'h80, 8'h02, 0, 16'h0100, "u128x2");
        mul(1, 8'h7F, 8'h7F, 1, 16'h3F01, "s127sq");
        mul(1, 8'hF9, 8'h03, 1, 16'hFFEB, "sm7x3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
